// File: rtl/writeback_unit_if.sv
// Bundle between the execute/memory stage, data memory and the writeback
// unit, plus the regfile write port that decode consumes.
interface writeback_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT;
  logic [4:0]  WRITEBACK_TO_DECODE_REG_ID_OUT;
  logic [31:0] WRITEBACK_TO_DECODE_DATA_OUT;
  logic [31:0] retired_count;

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result, in_pc,
           in_funct3, mem_rvalid, mem_rdata,
    output in_ready, WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT,
           WRITEBACK_TO_DECODE_REG_ID_OUT, WRITEBACK_TO_DECODE_DATA_OUT,
           retired_count
  );

  modport master (
    output in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result, in_pc,
           in_funct3, mem_rvalid, mem_rdata,
    input  in_ready, WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT,
           WRITEBACK_TO_DECODE_REG_ID_OUT, WRITEBACK_TO_DECODE_DATA_OUT,
           retired_count
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: selects/format the result of each completed instruction
// and drives the regfile write port. Loads park in WAIT_MEM until the data
// memory answers, holding in_ready low meanwhile.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a new instruction; non-loads complete on accept
// WAIT_MEM | load accepted, waiting for mem_rvalid; upstream stalled
module writeback_unit (
  input  logic              clk,
  input  logic              rst,
  writeback_unit_if.slave   bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_MEM = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        pend_regw_q, pend_regw_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [2:0]  pend_f3_q, pend_f3_d;
  logic [1:0]  pend_lane_q, pend_lane_d;
  logic        we_q, we_d;
  logic [4:0]  id_q, id_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cnt_q, cnt_d;

  logic        done;
  logic        c_regw;
  logic [4:0]  c_rd;
  logic [31:0] c_data;

  function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                           input logic [1:0]  lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'd0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Next-state logic: accept/complete decisions and output register inputs.
  always_comb begin
    state_d     = state_q;
    pend_regw_d = pend_regw_q;
    pend_rd_d   = pend_rd_q;
    pend_f3_d   = pend_f3_q;
    pend_lane_d = pend_lane_q;
    done        = 1'b0;
    c_regw      = 1'b0;
    c_rd        = 5'd0;
    c_data      = 32'd0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_wb_sel == 2'd1) begin
            pend_regw_d = bus.in_reg_write;
            pend_rd_d   = bus.in_rd;
            pend_f3_d   = bus.in_funct3;
            pend_lane_d = bus.in_alu_result[1:0];
            state_d     = WAIT_MEM;
          end else begin
            done   = 1'b1;
            c_regw = bus.in_reg_write;
            c_rd   = bus.in_rd;
            c_data = (bus.in_wb_sel == 2'd2) ? bus.in_pc + 32'd4
                                             : bus.in_alu_result;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          done    = 1'b1;
          c_regw  = pend_regw_q;
          c_rd    = pend_rd_q;
          c_data  = fmt_load(pend_f3_q, pend_lane_q, bus.mem_rdata);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // x0 is hardwired to zero, so its write is dropped but id/data still show
    we_d   = done & c_regw & (c_rd != 5'd0);
    id_d   = done ? c_rd : id_q;
    data_d = done ? c_data : data_q;
    cnt_d  = done ? cnt_q + 32'd1 : cnt_q;
  end

  // State and output registers; reset also drops any load in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_regw_q <= 1'b0;
      pend_rd_q   <= 5'd0;
      pend_f3_q   <= 3'd0;
      pend_lane_q <= 2'd0;
      we_q        <= 1'b0;
      id_q        <= 5'd0;
      data_q      <= 32'd0;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      pend_regw_q <= pend_regw_d;
      pend_rd_q   <= pend_rd_d;
      pend_f3_q   <= pend_f3_d;
      pend_lane_q <= pend_lane_d;
      we_q        <= we_d;
      id_q        <= id_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready                             = (state_q == IDLE);
  assign bus.WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT = we_q;
  assign bus.WRITEBACK_TO_DECODE_REG_ID_OUT       = id_q;
  assign bus.WRITEBACK_TO_DECODE_DATA_OUT         = data_q;
  assign bus.retired_count                        = cnt_q;

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the single-cycle/pipelined RISC-V core: it accepts completed instructions from execute/memory, selects and formats the result (ALU, sign/zero-extended load data, or PC+4), and drives the register-file write port consumed by decode. It is the write side of the decode/regfile interface. Loads wait in a small state machine for the data-memory response, back-pressuring the upstream stage. A retired-instruction counter is kept for debug.

## Interface
- No parameters; all widths fixed (XLEN 32, 5-bit register ids).
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  unit can accept; transfer when in_valid & in_ready at a rising edge.
- in_reg_write  input  1  instruction writes rd.
- in_rd  input  5  destination register id.
- in_wb_sel  input  2  0 = ALU, 1 = load, 2 = PC+4, 3 = reserved (treated as ALU).
- in_alu_result  input  32  ALU result; also the load address.
- in_pc  input  32  instruction PC.
- in_funct3  input  3  load width/sign code.
- mem_rvalid  input  1  data-memory read response valid.
- mem_rdata  input  32  aligned 32-bit word from data memory.
- WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT  output  1  regfile write enable.
- WRITEBACK_TO_DECODE_REG_ID_OUT  output  5  regfile write id.
- WRITEBACK_TO_DECODE_DATA_OUT  output  32  regfile write data.
- retired_count  output  32  instructions completed since reset.

## Operation
- States: IDLE, WAIT_MEM. in_ready = 1 in IDLE, 0 in WAIT_MEM.
- IDLE, accept with in_wb_sel != 1: latch result into output registers; stay IDLE.
  - Data: ALU/reserved → in_alu_result; PC+4 → in_pc + 32'd4 (mod 2^32, carry dropped).
- IDLE, accept with in_wb_sel = 1: capture in_rd, in_reg_write, in_funct3, in_alu_result[1:0]; go WAIT_MEM.
- WAIT_MEM: on mem_rvalid, format mem_rdata, drive outputs, return IDLE. mem_rvalid in IDLE is ignored.
- Load formatting (byte lane = addr[1:0], half lane = addr[1], addr[0] ignored for halves):
  - 000 lb: sign-extend byte; 100 lbu: zero-extend byte.
  - 001 lh: sign-extend half; 101 lhu: zero-extend half.
  - 010 lw and all other codes: full word.
- Write enable = completion pulse & reg_write & (rd != 0); x0 is never written. REG_ID_OUT and DATA_OUT carry the values even when the enable is suppressed.
- retired_count increments by 1 on every completion pulse (write-suppressed included); wraps 2^32-1 → 0.
- Reset (rst = 0 at an edge): state IDLE; WRITE_EN_OUT 0; REG_ID_OUT 0; DATA_OUT 0; retired_count 0; any pending load discarded with no write, also mid-WAIT_MEM.

## Timing
- Non-load accepted at edge N → WRITE_EN_OUT high for exactly the cycle after edge N; deasserts at edge N+1 unless another completion occurs.
- Back-to-back non-loads: one completion per cycle, in_ready held high.
- Load accepted at edge N → WAIT_MEM from N; earliest mem_rvalid sampled at edge N+1. Response at edge M → write in the cycle after M; in_ready high in that same cycle, so a new accept at edge M+1.
- Load-to-use: the decode regfile sees the write at the edge ending the write cycle; any bypass is outside this block.
- All outputs are registered; no combinational path from inputs to outputs except in_ready, which depends only on state.

## Test plan
- Reset: hold rst = 0 two cycles with in_valid = 1 → all outputs 0, no writes; release → in_ready = 1.
- ALU stream: accept rd = 5, 0x1234 then rd = 6, 0xFFFFFFFF on consecutive edges → write pulses on consecutive cycles with matching id/data; retired_count = 2.
- PC+4 / x0: PC+4 with in_pc = 0xFFFFFFFC, rd = 1 → data 0x00000000; then ALU to rd = 0 → enable 0, retired_count still increments.
- Loads: mem_rdata = 0x80FF7F01; lb addr 3 → 0xFFFFFF80; lbu addr 1 → 0x0000007F; lh addr 2 → 0xFFFF80FF; lhu addr 0 → 0x00007F01; lw → 0x80FF7F01.
- Back-pressure: load accepted, mem_rvalid delayed 3 cycles while in_valid held → in_ready 0 for exactly those cycles; no extra accepts; next instruction accepted in the write cycle.
- Reset mid-load: rst = 0 during WAIT_MEM, then mem_rvalid = 1 → no write; state IDLE; retired_count 0.
